// File: rtl/mux_81_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_81_serializer_pkg
// Description : Shared widths, FSM encodings and helpers for the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_81_serializer_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Index of the first bit sent in a frame for the chosen bit order.
    function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
        return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_81_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_81_serializer_if
// Description : Byte-in / bit-out handshake bundle for the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_81_serializer_if;
    import mux_81_serializer_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ser_ready;
    logic              ser_valid;
    logic              ser_out;
    logic [SEL_W-1:0]  sel;
    logic              frame_done;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_out, sel, frame_done
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_out, sel, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/mux_81_behav.sv
`default_nettype none
// ============================================================================
// Module      : mux_81_behav
// Description : Behavioural 8:1 bit multiplexer, y = in[s].
// Revision    : 1.0 - initial release
// ============================================================================
module mux_81_behav
    import mux_81_serializer_pkg::*;
(
    input  wire logic [DATA_W-1:0] in,
    input  wire logic [SEL_W-1:0]  s,
    output logic                   y
);

    assign y = in[s];

endmodule
`default_nettype wire

// File: rtl/mux_81_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mux_81_serializer
// Description : Latches a byte and walks the 8:1 mux select to emit it serially.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_81_serializer
    import mux_81_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux_81_serializer_if.slave bus
);

    localparam logic [SEL_W-1:0] c_start = sel_start(MSB_FIRST);
    localparam logic [SEL_W-1:0] c_last  = ~c_start;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_word;
    logic [SEL_W-1:0]  r_sel;
    logic              r_frame_done;

    logic w_accept;
    logic w_is_last;
    logic w_in_ready;
    logic w_load;
    logic w_ser_out;

    assign w_accept   = (r_state == ST_SHIFT) & bus.ser_ready;
    assign w_is_last  = (r_sel == c_last);
    // Accepting the next word on the last-bit cycle gives zero-bubble frames.
    assign w_in_ready = (r_state == ST_IDLE) | (w_accept & w_is_last);
    assign w_load     = bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_sel        <= c_start;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept & w_is_last;
            if (w_load) begin
                r_word  <= bus.in_data;
                r_sel   <= c_start;
                r_state <= ST_SHIFT;
            end else if (w_accept) begin
                if (w_is_last) begin
                    r_state <= ST_IDLE;
                end else if (MSB_FIRST) begin
                    r_sel <= r_sel - SEL_W'(1);
                end else begin
                    r_sel <= r_sel + SEL_W'(1);
                end
            end
        end
    end

    mux_81_behav u_mux (
        .in (r_word),
        .s  (r_sel),
        .y  (w_ser_out)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.ser_valid  = (r_state == ST_SHIFT);
    assign bus.ser_out    = w_ser_out;
    assign bus.sel        = r_sel;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
